// File: rtl/wqe_wrr_schedule.sv
// wqe_wrr_schedule: weighted round-robin QP picker for the TX WQE read engine.
// Each QP receives up to weight[q] consecutive grants before the pointer moves on.
module wqe_wrr_schedule #(
    parameter int MAX_QP = 256,
    parameter int QP_PTR_WIDTH = $clog2(MAX_QP),
    parameter int WEIGHT_WIDTH = 4,
    parameter int WEIGHT_DEFAULT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_arbit,
    input  logic                    i_enable,
    input  logic [MAX_QP-1:0]       i_active,
    input  logic                    i_cfg_we,
    input  logic [QP_PTR_WIDTH-1:0] i_cfg_qp,
    input  logic [WEIGHT_WIDTH-1:0] i_cfg_weight,
    output logic                    o_arbit_val,
    output logic [QP_PTR_WIDTH-1:0] o_qp_idx,
    output logic [MAX_QP-1:0]       o_qp_idx_one_hot,
    output logic                    o_burst_last
);
    localparam logic [QP_PTR_WIDTH:0] QP_N = (QP_PTR_WIDTH+1)'(MAX_QP);
    localparam logic [QP_PTR_WIDTH-1:0] QP_LAST = QP_PTR_WIDTH'(MAX_QP - 1);
    localparam logic [MAX_QP-1:0] ONE = MAX_QP'(1);

    logic [WEIGHT_WIDTH-1:0] weight [MAX_QP];
    logic [WEIGHT_WIDTH-1:0] credit, next_credit;
    logic [QP_PTR_WIDTH-1:0] cur_ptr, start, off, hit_qp, grant_qp;
    logic [QP_PTR_WIDTH:0]   sum;
    logic [MAX_QP-1:0]       elig, rot;
    logic [2*MAX_QP-1:0]     dbl;
    logic                    cont, hit, grant;

    always_comb begin
        for (int i = 0; i < MAX_QP; i++) elig[i] = i_active[i] & (weight[i] != '0);
    end

    // Rotate so the slot after cur_ptr is bit 0, find lowest set bit, rotate back.
    assign start = (cur_ptr == QP_LAST) ? '0 : cur_ptr + QP_PTR_WIDTH'(1);
    assign dbl = {elig, elig} >> start;
    assign rot = dbl[MAX_QP-1:0];

    always_comb begin
        off = '0;
        for (int i = MAX_QP - 1; i >= 0; i--) if (rot[i]) off = QP_PTR_WIDTH'(i);
    end

    assign hit = |rot;
    assign sum = {1'b0, start} + {1'b0, off};
    assign hit_qp = (sum >= QP_N) ? QP_PTR_WIDTH'(sum - QP_N) : sum[QP_PTR_WIDTH-1:0];
    assign cont = (credit != '0) & elig[cur_ptr];
    assign grant = i_arbit & i_enable & (cont | hit);
    assign grant_qp = cont ? cur_ptr : hit_qp;
    assign next_credit = cont ? credit - WEIGHT_WIDTH'(1) : weight[hit_qp] - WEIGHT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_arbit_val <= 1'b0;
            o_qp_idx <= '0;
            o_qp_idx_one_hot <= '0;
            o_burst_last <= 1'b0;
            cur_ptr <= QP_LAST;
            credit <= '0;
            for (int i = 0; i < MAX_QP; i++) weight[i] <= WEIGHT_WIDTH'(WEIGHT_DEFAULT);
        end else begin
            if (i_cfg_we) weight[i_cfg_qp] <= i_cfg_weight;
            o_arbit_val <= grant;
            o_qp_idx_one_hot <= grant ? ONE << grant_qp : '0;
            o_burst_last <= grant & (next_credit == '0);
            if (grant) begin
                o_qp_idx <= grant_qp;
                cur_ptr <= grant_qp;
                credit <= next_credit;
            end
        end
    end
endmodule

// File: tb/tb_wqe_wrr_schedule.sv
// tb_wqe_wrr_schedule: directed plan plus random traffic against a behavioural WRR model.
module tb_wqe_wrr_schedule;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_arbit = 1'b0;
    logic       i_enable = 1'b1;
    logic [7:0] i_active = '0;
    logic       i_cfg_we = 1'b0;
    logic [2:0] i_cfg_qp = '0;
    logic [3:0] i_cfg_weight = '0;
    logic       o_arbit_val;
    logic [2:0] o_qp_idx;
    logic [7:0] o_qp_idx_one_hot;
    logic       o_burst_last;

    int vectors = 0;
    int miscompares = 0;
    int m_ptr, m_credit;
    int m_w[N];
    bit e_val, e_last;
    int e_idx;
    int t1[10] = '{2, 3, 4, 5, 6, 7, 2, 3, 4, 5};
    int t2[8] = '{2, 2, 2, 5, 5, 2, 2, 2};
    bit t2_last[8] = '{0, 0, 1, 0, 1, 0, 0, 1};

    wqe_wrr_schedule #(.MAX_QP(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_arbit(i_arbit),
        .i_enable(i_enable),
        .i_active(i_active),
        .i_cfg_we(i_cfg_we),
        .i_cfg_qp(i_cfg_qp),
        .i_cfg_weight(i_cfg_weight),
        .o_arbit_val(o_arbit_val),
        .o_qp_idx(o_qp_idx),
        .o_qp_idx_one_hot(o_qp_idx_one_hot),
        .o_burst_last(o_burst_last)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit eligible(int q);
        return i_active[q] && m_w[q] != 0;
    endfunction

    // Model the decision from the inputs present before the edge, then compare after it.
    task automatic tick();
        bit in_reset = !rst_n;
        e_val = 0;
        e_last = 0;
        if (in_reset) begin
            m_ptr = N - 1;
            m_credit = 0;
            e_idx = 0;
            foreach (m_w[i]) m_w[i] = 1;
        end else begin
            if (i_arbit && i_enable) begin
                if (m_credit > 0 && eligible(m_ptr)) begin
                    e_val = 1;
                    e_idx = m_ptr;
                    m_credit--;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        int q = (m_ptr + k) % N;
                        if (!e_val && eligible(q)) begin
                            e_val = 1;
                            e_idx = q;
                            m_ptr = q;
                            m_credit = m_w[q] - 1;
                        end
                    end
                end
                e_last = e_val && m_credit == 0;
            end
            if (i_cfg_we) m_w[i_cfg_qp] = int'(i_cfg_weight);
        end
        @(posedge clk);
        #1;
        check("val", {31'd0, o_arbit_val}, {31'd0, e_val});
        check("last", {31'd0, o_burst_last}, {31'd0, e_last});
        check("onehot", {24'd0, o_qp_idx_one_hot}, e_val ? 32'd1 << e_idx : 32'd0);
        if (e_val || in_reset) check("idx", {29'd0, o_qp_idx}, e_idx);
    endtask

    task automatic pulse(int n);
        for (int i = 0; i < n; i++) begin
            i_arbit = 1'b1;
            tick();
            i_arbit = 1'b0;
            tick();
        end
    endtask

    task automatic set_w(int q, int w);
        i_cfg_we = 1'b1;
        i_cfg_qp = 3'(q);
        i_cfg_weight = 4'(w);
        tick();
        i_cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        i_active = 8'hFC;
        for (int i = 0; i < 10; i++) begin
            i_arbit = 1'b1;
            tick();
            check("t1_idx", {29'd0, o_qp_idx}, t1[i]);
            i_arbit = 1'b0;
            tick();
        end
        set_w(2, 3);
        set_w(5, 2);
        i_active = 8'h24;
        for (int i = 0; i < 8; i++) begin
            i_arbit = 1'b1;
            tick();
            check("t2_idx", {29'd0, o_qp_idx}, t2[i]);
            check("t2_last", {31'd0, o_burst_last}, {31'd0, t2_last[i]});
            i_arbit = 1'b0;
            tick();
        end
        set_w(3, 0);
        i_active = 8'h08;
        pulse(3);
        i_active = 8'h00;
        pulse(2);
        i_active = 8'h10;
        pulse(2);
        set_w(1, 4);
        i_active = 8'h03;
        pulse(2);
        i_active = 8'h01;
        pulse(1);
        i_active = 8'h03;
        pulse(5);
        i_enable = 1'b0;
        pulse(5);
        i_enable = 1'b1;
        i_active = 8'h06;
        pulse(1);
        do_reset();
        pulse(3);
        do_reset();
        i_active = 8'hFF;
        i_arbit = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_cfg_we = (c == 3);
            i_cfg_qp = 3'd3;
            i_cfg_weight = 4'd3;
            tick();
            check("t6_idx", {29'd0, o_qp_idx}, c % 8);
        end
        i_cfg_we = 1'b0;
        i_arbit = 1'b0;
        tick();
        for (int c = 0; c < 600; c++) begin
            rst_n = $urandom_range(0, 99) != 0;
            i_arbit = $urandom_range(0, 3) != 0;
            i_enable = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 3) == 0) i_active = 8'($urandom);
            i_cfg_we = $urandom_range(0, 5) == 0;
            i_cfg_qp = 3'($urandom);
            i_cfg_weight = 4'($urandom_range(0, 5));
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
